// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and sizing constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous-write, registered-read word array with per-byte write mask
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [AW-1:0]         idx,
  input  logic [W-1:0]          wdata,
  input  logic [WORD_BYTES-1:0] wmask,
  output logic [W-1:0]          rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int b = 0; b < WORD_BYTES; b++)
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  // read register doubles as the response data, so it is zeroed on reset and handshake
  always_ff @(posedge clk)
    if (rst || clr) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store responder; DMEM_BYTE_STROBE_EN adds req_be byte-lane stores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic wr_q, err, full, access;
  logic [ADDR_W-1:0] addr_q, widx;
  logic [DATA_W-1:0] wdata_q;
  logic [WORD_BYTES-1:0] mask;
`ifdef DMEM_BYTE_STROBE_EN
  logic [WORD_BYTES-1:0] be_q;
  assign mask = be_q;
  // partial-word stores may sit at any byte offset; loads and full stores must align
  assign full = !wr_q || be_q == '1;
`else
  assign mask = '1;
  assign full = 1'b1;
`endif
  assign widx = addr_q >> 2;
  assign err = (full && addr_q[1:0] != 2'b00) || widx >= ADDR_W'(DEPTH_WORDS);
  assign access = state == WAIT && cnt == '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          wr_q <= req_write;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
          be_q <= req_be;
`endif
          cnt <= CNT_W'(WAIT_CYCLES);
          req_ready <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rsp_valid <= 1'b1;
          rsp_err <= err;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW), .W(DATA_W)) u_array (
    .clk(clk),
    .rst(rst),
    .we(access && wr_q && !err && !rst),
    .re(access && !wr_q && !err && !rst),
    .clr(state == RESP && rsp_ready),
    .idx(widx[AW-1:0]),
    .wdata(wdata_q),
    .wmask(mask),
    .rdata(rsp_rdata)
  );
endmodule
